// File: rtl/serial_slave_port_pkg.sv
// Shared serial-bus definitions: slave FSM states, transfer mode encoding and
// the bit-counter sizing helper used by both bus endpoints.
package serial_slave_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_ACCESS,
    ST_RDATA
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // One spare bit so the counter can hold the full field length itself.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/serial_slave_port_if.sv
// Serial bus lines plus the parallel peripheral port of one slave position.
interface serial_slave_port_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);

  logic                  bwdata;
  logic                  bmode;
  logic                  bwvalid;
  logic                  brdata;
  logic                  brvalid;
  logic                  sready;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  timeout_err;

  modport slave (
    input  bwdata, bmode, bwvalid, mem_rdata, mem_ack,
    output brdata, brvalid, sready, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport master (
    output bwdata, bmode, bwvalid, mem_rdata, mem_ack,
    input  brdata, brvalid, sready, mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

endinterface

// File: rtl/serial_piso.sv
// Parallel-in serial-out register: loads a word and presents it LSB first,
// one bit per shift.
module serial_piso #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  dout
);

  logic [DATA_WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= sr_q >> 1;
    end
  end

  assign dout = sr_q[0];

endmodule

// File: rtl/serial_slave_port.sv
// serial_slave_port: bit-serial bus responder that turns each received
// transaction into one req/ack access on a parallel peripheral port.
module serial_slave_port
  import serial_slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input logic                clk,
  input logic                rstn,
  serial_slave_port_if.slave bus
);

  localparam int CW      = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int TO_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

  localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_WIDTH - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TO_LAST);

  state_t                state_q, state_d;
  logic                  mode_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TW-1:0]         timer_q;

  logic                  mem_req_q, mem_we_q, brvalid_q, timeout_q;
  logic                  mem_req_d, mem_we_d, brvalid_d, timeout_d;
  logic                  piso_load, piso_shift, piso_dout;
  logic [DATA_WIDTH-1:0] piso_din;

  logic addr_bit, data_bit, cnt_last, next_mode, timeout_hit;

  assign addr_bit  = bus.bwvalid && (state_q == ST_IDLE || state_q == ST_ADDR);
  assign data_bit  = bus.bwvalid && (state_q == ST_WDATA);
  assign cnt_last  = (state_q == ST_WDATA || state_q == ST_RDATA) ? (bit_cnt_q == DATA_LAST)
                                                                  : (bit_cnt_q == ADDR_LAST);
  // bmode only counts with the first address bit; afterwards the latched copy rules.
  assign next_mode   = (state_q == ST_IDLE) ? bus.bmode : mode_q;
  assign timeout_hit = (ACK_TIMEOUT != 0) && (timer_q == TIMER_LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ADDR: begin
        if (addr_bit) begin
          if (!cnt_last)                     state_d = ST_ADDR;
          else if (next_mode == MODE_WRITE)  state_d = ST_WDATA;
          else                               state_d = ST_ACCESS;
        end
      end
      ST_WDATA: begin
        if (data_bit && cnt_last) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.mem_ack || timeout_hit) begin
          state_d = (mode_q == MODE_WRITE) ? ST_IDLE : ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (cnt_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    mem_req_d  = (state_d == ST_ACCESS);
    mem_we_d   = (state_d == ST_ACCESS) && (next_mode == MODE_WRITE);
    brvalid_d  = (state_d == ST_RDATA);
    timeout_d  = (state_q == ST_ACCESS) && !bus.mem_ack && timeout_hit;
    piso_load  = (state_q == ST_ACCESS) && (state_d == ST_RDATA);
    piso_shift = (state_q == ST_RDATA);
    piso_din   = bus.mem_ack ? bus.mem_rdata : '1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      brvalid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      brvalid_q <= brvalid_d;
      timeout_q <= timeout_d;
    end
  end

  // Receive shift: new bits enter at the MSB so the first bit ends up at bit 0.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q    <= MODE_READ;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      timer_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.bwvalid) mode_q <= bus.bmode;
      if (addr_bit) addr_q  <= (addr_q >> 1) | (ADDR_WIDTH'(bus.bwdata) << (ADDR_WIDTH - 1));
      if (data_bit) wdata_q <= (wdata_q >> 1) | (DATA_WIDTH'(bus.bwdata) << (DATA_WIDTH - 1));
      if (addr_bit || data_bit || state_q == ST_RDATA) begin
        bit_cnt_q <= cnt_last ? '0 : bit_cnt_q + 1'b1;
      end
      timer_q <= (state_q == ST_ACCESS && state_d == ST_ACCESS) ? timer_q + 1'b1 : '0;
    end
  end

  serial_piso #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_piso (
    .clk   (clk),
    .rstn  (rstn),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (piso_din),
    .dout  (piso_dout)
  );

  assign bus.brdata      = piso_dout;
  assign bus.brvalid     = brvalid_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.timeout_err = timeout_q;
  assign bus.sready      = !rstn || state_q == ST_IDLE || state_q == ST_ADDR || state_q == ST_WDATA;

endmodule

// File: tb/tb_serial_slave_port.sv
// Bench for serial_slave_port: table of bus transactions against a scripted
// peripheral, with a scoreboard checking each parallel access and read burst.
module tb_serial_slave_port;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    int          gap;
    int          wait_c;
    logic        noack;
    logic [7:0]  rdata;
    int          exp_req;
    logic        exp_tmo;
    logic [7:0]  exp_word;
  } vec_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    int          req_cycles;
    logic        tmo;
    logic [7:0]  word;
  } exp_t;

  logic clk;
  logic rstn;

  serial_slave_port_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) bus ();

  serial_slave_port #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (8),
    .ACK_TIMEOUT (64)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   n_tmo = 0, n_tmo_exp = 0, n_bursts = 0, n_reads_exp = 0;

  int         p_wait = 0;
  logic       p_noack = 1'b0;
  logic [7:0] p_rdata = 8'h00;
  int         p_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Peripheral: acks after p_wait cycles of mem_req; random stray acks otherwise.
  always @(negedge clk) begin
    if (rstn && bus.mem_req) begin
      bus.mem_ack   = !p_noack && (p_cnt == p_wait);
      bus.mem_rdata = bus.mem_ack ? p_rdata : 8'($urandom);
      p_cnt++;
    end else begin
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = 8'($urandom);
      p_cnt         = 0;
    end
  end

  // Scoreboard monitor.
  logic       prev_req = 1'b0, prev_bv = 1'b0;
  int         req_len = 0, rd_bits = 0;
  logic [7:0] rd_word = 8'h00;
  exp_t       cur;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_req = 1'b0;
      prev_bv  = 1'b0;
      req_len  = 0;
      rd_bits  = 0;
    end else begin
      if (bus.mem_req && !prev_req) begin
        check("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        check("req_sready", 32'(bus.sready), 32'd0);
        req_len = 0;
      end
      if (bus.mem_req) begin
        req_len++;
        check("req_we", 32'(bus.mem_we), 32'(cur.we));
        check("req_addr", 32'(bus.mem_addr), 32'(cur.addr));
        if (cur.we) check("req_wdata", 32'(bus.mem_wdata), 32'(cur.wdata));
      end
      if (!bus.mem_req && prev_req) begin
        check("req_len", 32'(req_len), 32'(cur.req_cycles));
        check("timeout_err", 32'(bus.timeout_err), 32'(cur.tmo));
        check("rd_start", 32'(bus.brvalid), 32'(!cur.we));
      end
      if (bus.timeout_err) n_tmo++;
      if (bus.brvalid) begin
        rd_word = {bus.brdata, rd_word[7:1]};
        rd_bits++;
      end else if (prev_bv) begin
        n_bursts++;
        check("rd_bits", 32'(rd_bits), 32'd8);
        check("rd_word", 32'(rd_word), 32'(cur.word));
        rd_bits = 0;
      end
      prev_req = bus.mem_req;
      prev_bv  = bus.brvalid;
    end
  end

  task automatic drive_bit(input logic b, input logic m);
    bus.bwvalid = 1'b1;
    bus.bwdata  = b;
    bus.bmode   = m;
    @(negedge clk);
    bus.bwvalid = 1'b0;
    bus.bwdata  = 1'($urandom);
    bus.bmode   = 1'($urandom);
  endtask

  task automatic idle_gap(input int max_gap);
    int g;
    g = $urandom_range(max_gap, 0);
    repeat (g) @(negedge clk);
  endtask

  task automatic send(input logic we, input logic [11:0] addr, input logic [7:0] data,
                      input int max_gap);
    for (int i = 0; i < 12; i++) begin
      drive_bit(addr[i], (i == 0) ? we : 1'($urandom));
      if (we || i != 11) idle_gap(max_gap);
    end
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        drive_bit(data[i], 1'($urandom));
        if (i != 7) idle_gap(max_gap);
      end
    end
    check("req_rise", 32'(bus.mem_req), 32'd1);
    check("sready_drop", 32'(bus.sready), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus.sready && !bus.mem_req && !bus.brvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(n < 300), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_access(input logic we, input logic [11:0] addr, input logic [7:0] wdata,
                               input int req_cycles, input logic tmo, input logic [7:0] word);
    exp_q.push_back('{we, addr, wdata, req_cycles, tmo, word});
    n_tmo_exp += int'(tmo);
    if (!we) n_reads_exp++;
  endtask

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin
    int n;
    //           we    addr     wdata  gap wait noack  rdata  req tmo   word
    vecs[0]  = '{1'b1, 12'h2A5, 8'h3C, 0,  1,   1'b0, 8'h00, 2,  1'b0, 8'h00};
    vecs[1]  = '{1'b0, 12'h011, 8'h00, 0,  5,   1'b0, 8'hA7, 6,  1'b0, 8'hA7};
    vecs[2]  = '{1'b1, 12'h2A5, 8'h3C, 3,  0,   1'b0, 8'h00, 1,  1'b0, 8'h00};
    vecs[3]  = '{1'b0, 12'hFFF, 8'h00, 2,  0,   1'b0, 8'h5A, 1,  1'b0, 8'h5A};
    vecs[4]  = '{1'b1, 12'h000, 8'hFF, 0,  3,   1'b0, 8'h00, 4,  1'b0, 8'h00};
    vecs[5]  = '{1'b0, 12'h456, 8'h00, 1,  0,   1'b1, 8'h00, 64, 1'b1, 8'hFF};
    vecs[6]  = '{1'b0, 12'h800, 8'h00, 0,  2,   1'b0, 8'h01, 3,  1'b0, 8'h01};
    vecs[7]  = '{1'b1, 12'h7FF, 8'h80, 1,  0,   1'b0, 8'h00, 1,  1'b0, 8'h00};
    vecs[8]  = '{1'b0, 12'h123, 8'h00, 0,  63,  1'b0, 8'h3C, 64, 1'b0, 8'h3C};
    vecs[9]  = '{1'b1, 12'h555, 8'hAA, 0,  0,   1'b1, 8'h00, 64, 1'b1, 8'h00};
    vecs[10] = '{1'b1, 12'h0AA, 8'h55, 0,  63,  1'b0, 8'h00, 64, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 12'h0F0, 8'h00, 0,  62,  1'b0, 8'hC3, 63, 1'b0, 8'hC3};

    rstn        = 1'b0;
    bus.bwvalid = 1'b0;
    bus.bwdata  = 1'b0;
    bus.bmode   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_brdata", 32'(bus.brdata), 32'd0);
    check("rst_brvalid", 32'(bus.brvalid), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_sready", 32'(bus.sready), 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_sready", 32'(bus.sready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      p_wait  = vecs[i].wait_c;
      p_noack = vecs[i].noack;
      p_rdata = vecs[i].rdata;
      expect_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_req,
                    vecs[i].exp_tmo, vecs[i].exp_word);
      send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].gap);
      wait_idle();
      repeat (i % 3) @(negedge clk);
    end

    // Reset during WDATA bit 4 discards the write; a following read must be clean.
    p_wait  = 2;
    p_noack = 1'b0;
    p_rdata = 8'h96;
    for (int i = 0; i < 12; i++) drive_bit((i % 3) == 0, (i == 0) ? 1'b1 : 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    bus.bwvalid = 1'b1;
    bus.bwdata  = 1'b1;
    rstn        = 1'b0;
    @(negedge clk);
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("midrst_sready", 32'(bus.sready), 32'd1);
    bus.bwvalid = 1'b0;
    rstn        = 1'b1;
    @(negedge clk);
    expect_access(1'b0, 12'h3C3, 8'h00, 3, 1'b0, 8'h96);
    send(1'b0, 12'h3C3, 8'h00, 1);
    wait_idle();

    // Back-to-back: read's first bit lands in the first IDLE cycle after the write.
    p_wait  = 1;
    p_rdata = 8'h6E;
    expect_access(1'b1, 12'h3A1, 8'hD2, 2, 1'b0, 8'h00);
    expect_access(1'b0, 12'h05C, 8'h00, 2, 1'b0, 8'h6E);
    send(1'b1, 12'h3A1, 8'hD2, 0);
    n = 0;
    while (!bus.sready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b_sready_return", 32'(n), 32'd2);
    send(1'b0, 12'h05C, 8'h00, 0);
    wait_idle();
    repeat (3) @(negedge clk);

    check("timeout_pulses", 32'(n_tmo), 32'(n_tmo_exp));
    check("read_bursts", 32'(n_bursts), 32'(n_reads_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000");
    $fatal(1);
  end

endmodule
